spi_master: RTL

Parameterised SPI controller: a successor to the single-mode, transmit-only serialiser. It supports all four SPI modes (runtime CPOL/CPHA), full-duplex capture on CIPO, and NUM_CS one-hot active-low chip selects. It sits between the design's command logic and off-chip SPI peripherals, and has a busy/done handshake so upstream logic can stream words back-to-back.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_edge_timer.sv | 43 ++++
 rtl/spi_master.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, SPI modes and
// the bit positions of CPOL/CPHA inside the 2-bit mode word.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_t;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_edge_timer.sv
// Half-period and edge counters for the SPI master: strobes every dclk toggle
// and reports whether that toggle is a leading edge and whether it is the last.
module spi_edge_timer #(
    parameter int DATA_WIDTH = 8,
    parameter int HALF       = 50
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    input  logic run,
    output logic tick,
    output logic leading,
    output logic last_edge
);

    localparam int HW = $clog2(HALF);
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [HW-1:0] HMAX  = HW'(HALF - 1);
    localparam logic [EW-1:0] ELAST = EW'(2 * DATA_WIDTH - 1);

    logic [HW-1:0] hcnt;
    logic [EW-1:0] ecnt;
    logic          wrap;

    assign wrap = (hcnt == HMAX);

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            hcnt <= '0;
            ecnt <= '0;
        end else if (run) begin
            hcnt <= wrap ? '0 : hcnt + 1'b1;
            if (wrap)
                ecnt <= ecnt + 1'b1;
        end
    end

    // ecnt holds the number of toggles already made, so even means the next one is odd (leading).
    assign tick      = run && wrap;
    assign leading   = ~ecnt[0];
    assign last_edge = (ecnt == ELAST);

endmodule

// File: rtl/spi_master.sv
// Four-mode, full-duplex SPI master with one-hot active-low chip selects and a
// busy/done handshake that allows back-to-back words.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_PERIOD = 100,
    parameter int NUM_CS      = 1,
    localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CSW-1:0]        cs_in,
    input  logic [1:0]            mode_in,
    input  logic                  trigger_in,
    input  logic                  cipo_in,
    output logic                  copi_out,
    output logic                  dclk_out,
    output logic [NUM_CS-1:0]     sel_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int HALF = DATA_PERIOD >> 1;

    state_t                state, state_next;
    mode_t                 mode;
    logic [1:0]            mode_bits;
    logic                  cpol, cpha;
    logic [DATA_WIDTH-1:0] tx_shift, rx_shift;
    logic [NUM_CS-1:0]     sel_next;
    logic                  accept, finish, tick, leading, last_edge;
    logic                  shift_en, sample_en;

    assign accept    = (state == IDLE) && trigger_in && (32'(cs_in) < NUM_CS);
    assign mode_bits = mode;
    assign cpol      = mode_bits[CPOL_BIT];
    assign cpha      = mode_bits[CPHA_BIT];
    assign busy_out  = (state != IDLE);

    spi_edge_timer #(
        .DATA_WIDTH(DATA_WIDTH),
        .HALF      (HALF)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (accept),
        .run      (busy_out),
        .tick     (tick),
        .leading  (leading),
        .last_edge(last_edge)
    );

    always_comb begin
        sel_next = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (32'(cs_in) == i) sel_next[i] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        finish     = 1'b0;
        unique case (state)
            IDLE: if (accept) state_next = XFER;
            XFER: if (tick && last_edge) state_next = HOLD;
            HOLD: if (tick) begin
                state_next = IDLE;
                finish     = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // CPHA=0 has its MSB out before the first edge, so the final trailing edge shifts nothing.
    assign shift_en  = (state == XFER) && tick && (cpha ? leading : (!leading && !last_edge));
    assign sample_en = (state == XFER) && tick && (cpha ? !leading : leading);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode     <= MODE0;
            sel_out  <= '1;
            dclk_out <= 1'b0;
            copi_out <= 1'b0;
            done_out <= 1'b0;
            data_out <= '0;
        end else begin
            done_out <= 1'b0;
            if (accept) begin
                mode     <= mode_t'(mode_in);
                sel_out  <= sel_next;
                dclk_out <= mode_in[CPOL_BIT];
                if (!mode_in[CPHA_BIT])
                    copi_out <= data_in[DATA_WIDTH-1];
            end else begin
                if (state == XFER && tick)
                    dclk_out <= ~dclk_out;
                if (shift_en)
                    copi_out <= tx_shift[DATA_WIDTH-1];
                if (finish) begin
                    sel_out  <= '1;
                    dclk_out <= cpol;
                    done_out <= 1'b1;
                    data_out <= rx_shift;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            tx_shift <= mode_in[CPHA_BIT] ? data_in : {data_in[DATA_WIDTH-2:0], 1'b0};
            rx_shift <= '0;
        end else begin
            if (shift_en)
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            if (sample_en)
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], cipo_in};
        end
    end

endmodule
